// File: rtl/pipe_pkg.sv
// Shared constants, stage operation encoding and helpers for the elastic
// pipeline register and its per-stage building block.
package pipe_pkg;

    localparam int MAX_DEPTH = 16;
    localparam int MAX_CNT_W = $clog2(MAX_DEPTH + 1);

    typedef enum logic [1:0] {
        STAGE_HOLD  = 2'd0,
        STAGE_LOAD  = 2'd1,
        STAGE_DRAIN = 2'd2,
        STAGE_CLEAR = 2'd3
    } stage_op_t;

    // Width needed to count 0..depth valid stages.
    function automatic int occ_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

    function automatic logic [MAX_CNT_W-1:0] popcount(input logic [MAX_DEPTH-1:0] v);
        logic [MAX_CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < MAX_DEPTH; i++) begin
            cnt = cnt + MAX_CNT_W'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/elastic_stage.sv
// One valid/data stage of the elastic pipeline: loads when upstream offers
// data and this stage is empty or draining; clear has priority over transfers.
module elastic_stage
    import pipe_pkg::*;
#(
    parameter int                WIDTH     = 20,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             arst_in,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);

    logic             valid_reg;
    logic [WIDTH-1:0] data_reg;
    stage_op_t        op;

    // An empty stage always accepts, which is what lets bubbles collapse.
    assign in_ready = !valid_reg || out_ready;

    always_comb begin
        op = STAGE_HOLD;
        if (flush) begin
            op = STAGE_CLEAR;
        end else if (in_valid && in_ready) begin
            op = STAGE_LOAD;
        end else if (valid_reg && out_ready) begin
            op = STAGE_DRAIN;
        end
    end

    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            valid_reg <= 1'b0;
            data_reg  <= RESET_VAL;
        end else begin
            case (op)
                STAGE_CLEAR: begin
                    valid_reg <= 1'b0;
                    data_reg  <= RESET_VAL;
                end
                STAGE_LOAD: begin
                    valid_reg <= 1'b1;
                    data_reg  <= in_data;
                end
                // Data is kept on drain so the output only changes on a load.
                STAGE_DRAIN: begin
                    valid_reg <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign out_valid = valid_reg;
    assign out_data  = data_reg;

endmodule

// File: rtl/elastic_pipe_reg.sv
// DEPTH-stage elastic pipeline register with valid/ready handshakes,
// synchronous flush and a combinational occupancy count.
module elastic_pipe_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = 20,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int              CNT_W     = occ_width(DEPTH)
) (
    input  logic             clk,
    input  logic             arst_in,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] occupancy
);

    // Element i of each chain is the interface between stage i-1 and stage i;
    // element 0 is the producer side, element DEPTH the consumer side.
    logic             valid_chain [DEPTH+1];
    logic             ready_chain [DEPTH+1];
    logic [WIDTH-1:0] data_chain  [DEPTH+1];
    logic [MAX_DEPTH-1:0] valid_vec;

    assign valid_chain[0]     = in_valid;
    assign data_chain[0]      = in_data;
    assign ready_chain[DEPTH] = out_ready;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            elastic_stage #(
                .WIDTH     (WIDTH),
                .RESET_VAL (RESET_VAL)
            ) u_stage (
                .clk       (clk),
                .arst_in   (arst_in),
                .flush     (flush),
                .in_valid  (valid_chain[gi]),
                .in_data   (data_chain[gi]),
                .in_ready  (ready_chain[gi]),
                .out_valid (valid_chain[gi+1]),
                .out_data  (data_chain[gi+1]),
                .out_ready (ready_chain[gi+1])
            );
        end
    endgenerate

    // Flush blocks both handshakes during its cycle.
    assign in_ready  = ready_chain[0] && !flush;
    assign out_valid = valid_chain[DEPTH] && !flush;
    assign out_data  = data_chain[DEPTH];

    always_comb begin
        valid_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid_vec[i] = valid_chain[i+1];
        end
    end

    assign occupancy = CNT_W'(popcount(valid_vec));

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Randomised and directed bench for elastic_pipe_reg: an item-position model
// predicts every handshake, output word and occupancy of the DEPTH=3 instance.
module tb_elastic_pipe_reg;

    localparam int              W    = 20;
    localparam int              A_D  = 3;
    localparam logic [W-1:0]    A_RV = 20'hABCDE;
    localparam int              B_D  = 4;
    localparam int              C_D  = 2;

    logic clk = 1'b0;
    logic arst_in;
    always #5 clk = ~clk;

    logic         a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [W-1:0] a_in_data, a_out_data;
    logic [1:0]   a_occupancy;
    logic         b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [W-1:0] b_in_data, b_out_data;
    logic [2:0]   b_occupancy;
    logic         c_flush, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
    logic [W-1:0] c_in_data, c_out_data;
    logic [1:0]   c_occupancy;

    elastic_pipe_reg #(.WIDTH(W), .DEPTH(A_D), .RESET_VAL(A_RV)) u_a (
        .clk(clk), .arst_in(arst_in), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .occupancy(a_occupancy));

    elastic_pipe_reg #(.WIDTH(W), .DEPTH(B_D), .RESET_VAL(20'h0)) u_b (
        .clk(clk), .arst_in(arst_in), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .occupancy(b_occupancy));

    elastic_pipe_reg #(.WIDTH(W), .DEPTH(C_D), .RESET_VAL(20'h0)) u_c (
        .clk(clk), .arst_in(arst_in), .flush(c_flush),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
        .occupancy(c_occupancy));

    int total = 0;
    int bad   = 0;
    int area_total = 0;

    // Model of instance A: each queued item carries its stage position.
    int           m_pos[$];
    logic [W-1:0] m_data[$];
    logic [W-1:0] m_last;
    int           flushed = 0;
    int           dut_ins = 0;
    int           dut_outs = 0;
    logic         a_in_hs, a_out_hs;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: compare A against the model mid-cycle, advance the model,
    // then return 1 time unit after the rising edge.
    task automatic tick();
        logic exp_ir, exp_ov;
        int   np, prev_np;
        @(negedge clk);
        exp_ir = !a_flush && (m_pos.size() < A_D || a_out_ready);
        exp_ov = !a_flush && m_pos.size() > 0 && m_pos[0] == A_D - 1;
        check("a_in_ready", a_in_ready, exp_ir);
        check("a_out_valid", a_out_valid, exp_ov);
        check("a_occupancy", a_occupancy, m_pos.size());
        check("a_out_data", a_out_data, m_last);
        a_in_hs  = a_in_valid && a_in_ready;
        a_out_hs = a_out_valid && a_out_ready;
        if (a_in_hs) dut_ins++;
        if (a_out_hs) dut_outs++;
        if (a_flush) begin
            flushed += m_pos.size();
            m_pos.delete();
            m_data.delete();
            m_last = A_RV;
        end else begin
            if (exp_ov && a_out_ready) begin
                $display("xfer out data=%05h occ=%0d", m_data[0], m_pos.size());
                void'(m_pos.pop_front());
                void'(m_data.pop_front());
            end
            // An item advances one stage unless the item ahead blocks it.
            prev_np = A_D;
            foreach (m_pos[k]) begin
                np = (m_pos[k] + 1 < prev_np - 1) ? m_pos[k] + 1 : prev_np - 1;
                if (np == A_D - 1 && m_pos[k] != A_D - 1) m_last = m_data[k];
                m_pos[k] = np;
                prev_np  = np;
            end
            if (a_in_valid && exp_ir) begin
                m_pos.push_back(0);
                m_data.push_back(a_in_data);
                if (A_D == 1) m_last = a_in_data;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fill_a(input int base);
        a_out_ready = 1'b0;
        for (int k = 0; k < A_D; k++) begin
            a_in_valid = 1'b1;
            a_in_data  = W'(base + k);
            tick();
        end
        a_in_valid = 1'b0;
        check("a_fill_occ", a_occupancy, A_D);
    endtask

    task automatic drain_a();
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        a_flush     = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (m_pos.size() == 0) break;
            tick();
        end
        check("a_drain_occ", a_occupancy, 0);
    endtask

    initial begin
        int pend, acc, outs0, ins0, flush0;
        area_total += 17 * (W + 1) * A_D;
        area_total += 17 * (W + 1) * B_D;
        area_total += 17 * (W + 1) * C_D;
        $display("area: elastic_pipe_reg instances add %0d (total %0d)", area_total, area_total);

        arst_in = 1'b1;
        {a_flush, a_in_valid, a_out_ready} = '0;
        {b_flush, b_in_valid, b_out_ready} = '0;
        {c_flush, c_in_valid, c_out_ready} = '0;
        a_in_data = '0; b_in_data = '0; c_in_data = '0;
        m_last = A_RV;
        #12;
        check("rst_a_out_valid", a_out_valid, 0);
        check("rst_a_out_data", a_out_data, A_RV);
        check("rst_a_occ", a_occupancy, 0);
        check("rst_a_in_ready", a_in_ready, 1);
        arst_in = 1'b0;
        @(posedge clk);
        #1;

        // Streaming with no back-pressure.
        outs0 = dut_outs;
        for (int k = 1; k <= 8; k++) begin
            a_in_valid = 1'b1; a_in_data = W'(k); a_out_ready = 1'b1;
            tick();
        end
        drain_a();
        check("stream_outs", dut_outs - outs0, 8);

        // Back-pressure: only DEPTH items fit while the consumer stalls.
        a_out_ready = 1'b0;
        pend = 1; acc = 0;
        for (int k = 0; k < 5; k++) begin
            a_in_valid = 1'b1; a_in_data = W'(pend);
            tick();
            if (a_in_hs) begin pend++; acc++; end
        end
        check("bp_accepted", acc, 3);
        check("bp_occ", a_occupancy, 3);
        check("bp_in_ready", a_in_ready, 0);
        outs0 = dut_outs;
        a_out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            a_in_valid = (pend <= 5);
            a_in_data  = W'(pend);
            tick();
            if (a_in_hs) pend++;
        end
        check("bp_delivered", dut_outs - outs0, 5);
        drain_a();

        // Bubble collapse on the DEPTH=4 instance.
        b_out_ready = 1'b0; b_in_valid = 1'b1; b_in_data = 20'h0AAAA;
        tick();
        b_in_valid = 1'b0;
        tick(); tick();
        check("bub_in_ready0", b_in_ready, 1);
        b_in_valid = 1'b1; b_in_data = 20'h0BBBB;
        tick();
        b_in_valid = 1'b0;
        tick(); tick();
        check("bub_occ", b_occupancy, 2);
        check("bub_out_valid", b_out_valid, 1);
        check("bub_out_data", b_out_data, 20'h0AAAA);
        check("bub_in_ready1", b_in_ready, 1);
        b_out_ready = 1'b1;
        tick();
        check("bub_next_valid", b_out_valid, 1);
        check("bub_next_data", b_out_data, 20'h0BBBB);
        check("bub_next_occ", b_occupancy, 1);
        tick();
        check("bub_empty_valid", b_out_valid, 0);
        check("bub_empty_occ", b_occupancy, 0);
        b_out_ready = 1'b0;

        // Flush on a full pipe with both sides requesting.
        fill_a(32'h100);
        a_flush = 1'b1; a_in_valid = 1'b1; a_in_data = 20'h55555; a_out_ready = 1'b1;
        tick();
        check("flush_no_in_hs", a_in_hs, 0);
        check("flush_no_out_hs", a_out_hs, 0);
        a_flush = 1'b0; a_in_valid = 1'b0;
        check("flush_occ", a_occupancy, 0);
        check("flush_out_valid", a_out_valid, 0);
        check("flush_out_data", a_out_data, A_RV);
        tick();

        // Full pipe, simultaneous load and drain.
        fill_a(32'h200);
        ins0 = dut_ins; outs0 = dut_outs;
        a_out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            a_in_valid = 1'b1; a_in_data = W'(32'h300 + k);
            tick();
        end
        check("simul_ins", dut_ins - ins0, 10);
        check("simul_outs", dut_outs - outs0, 10);
        check("simul_occ", a_occupancy, A_D);
        drain_a();

        // Random stall scoreboard.
        ins0 = dut_ins; outs0 = dut_outs; flush0 = flushed;
        for (int k = 0; k < 10000; k++) begin
            a_in_valid  = $urandom_range(0, 1) == 1;
            a_in_data   = W'($urandom);
            a_out_ready = ($urandom % 4) != 0;
            a_flush     = ($urandom % 256) == 0;
            tick();
        end
        drain_a();
        check("rand_conserve", dut_outs - outs0, (dut_ins - ins0) - (flushed - flush0));

        // Asynchronous reset mid-stream.
        a_out_ready = 1'b0; c_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_data = 20'h77777;
        c_in_valid = 1'b1; c_in_data = 20'h11111;
        tick();
        a_in_data = 20'h78888; c_in_data = 20'h22222;
        tick();
        a_in_valid = 1'b0; c_in_valid = 1'b0;
        check("pre_rst_c_occ", c_occupancy, 2);
        check("pre_rst_c_data", c_out_data, 20'h11111);
        #1 arst_in = 1'b1;
        #1;
        check("arst_c_out_valid", c_out_valid, 0);
        check("arst_c_out_data", c_out_data, 0);
        check("arst_c_occ", c_occupancy, 0);
        check("arst_c_in_ready", c_in_ready, 1);
        check("arst_a_occ", a_occupancy, 0);
        check("arst_a_out_data", a_out_data, A_RV);
        m_pos.delete(); m_data.delete(); m_last = A_RV;
        #1 arst_in = 1'b0;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
